memory_access: RTL and testbench

MEMORY_ACCESS -- requirements
Module: memory_access

---
 rtl/memory_access_if.sv | 31 +++
 rtl/memory_access.sv | 168 ++++++++++++++++
 tb/tb_memory_access.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_access_if.sv
// memory_access_if: request/response bus between the memory-access stage
// and the data memory. The stage is the master; the memory is the slave.
interface memory_access_if;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_out;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_stall;
  logic        mem_done;
  logic [15:0] mem_data_in;

  modport master (
    output mem_addr,
    output mem_data_out,
    output mem_rd,
    output mem_wr,
    input  mem_stall,
    input  mem_done,
    input  mem_data_in
  );

  modport slave (
    input  mem_addr,
    input  mem_data_out,
    input  mem_rd,
    input  mem_wr,
    output mem_stall,
    output mem_done,
    output mem_data_in
  );
endinterface

// File: rtl/memory_access.sv
// memory_access: pipeline memory stage issuing one load/store at a time to a
// data memory that may back-pressure (mem_stall) and respond late (mem_done).
// Holds the pipeline while an access is outstanding, flags malformed requests
// and WAIT timeouts through a sticky err.
module memory_access #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic            memRead,
  input  logic            memWrite,
  input  logic [15:0]     aluOut,
  input  logic [15:0]     writeData,
  memory_access_if.master mem,
  output logic [15:0]     readData,
  output logic            stall,
  output logic            done,
  output logic            err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_e;

  localparam logic [4:0] TIMEOUT_W = 5'(TIMEOUT);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        load_q, load_d;
  logic        err_q, err_d;

  logic        accept;
  logic        reject;
  logic [4:0]  cnt_inc;

  // Request decode: a clean single memory op at an even address is accepted;
  // any other memory op (both flags set, or odd address) is a fault.
  always_comb begin
    accept = (state_q == S_IDLE) && valid_in && (memRead ^ memWrite)
             && !aluOut[0] && !err_q;
    reject = (state_q == S_IDLE) && valid_in && (memRead | memWrite)
             && !accept && !err_q;
  end

  // Next-state logic and capture of request/response registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    load_d  = load_q;
    err_d   = err_q;
    cnt_inc = {1'b0, cnt_q} + 5'd1;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_REQ;
          addr_d  = aluOut;
          wdata_d = writeData;
          load_d  = memRead;
          cnt_d   = '0;
        end else if (reject) begin
          err_d = 1'b1;
        end
      end
      S_REQ: begin
        if (!mem.mem_stall) begin
          if (mem.mem_done) begin
            state_d = S_DONE;
            if (load_q) rdata_d = mem.mem_data_in;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // A response arriving on the final allowed cycle still wins over
        // the timeout.
        if (mem.mem_done) begin
          state_d = S_DONE;
          if (load_q) rdata_d = mem.mem_data_in;
        end else if (cnt_inc >= TIMEOUT_W) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc[3:0];
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      load_q  <= load_d;
      err_q   <= err_d;
    end
  end

  // Output decode; forced quiet while rst is high so the bus is idle even
  // before the reset edge lands.
  always_comb begin
    stall            = 1'b0;
    done             = 1'b0;
    mem.mem_rd       = 1'b0;
    mem.mem_wr       = 1'b0;
    mem.mem_addr     = '0;
    mem.mem_data_out = '0;
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          stall = accept;
        end
        S_REQ: begin
          stall            = 1'b1;
          mem.mem_rd       = load_q;
          mem.mem_wr       = !load_q;
          mem.mem_addr     = addr_q;
          mem.mem_data_out = wdata_q;
        end
        S_WAIT: begin
          stall            = 1'b1;
          mem.mem_addr     = addr_q;
          mem.mem_data_out = wdata_q;
        end
        S_DONE: begin
          done = 1'b1;
        end
        default: begin
          stall = 1'b0;
        end
      endcase
    end
  end

  assign readData = rdata_q;
  assign err      = err_q;

endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: directed and randomized transactions against a
// transaction-level expectation of cycle counts, bus contents and flags.
module tb_memory_access;

  localparam int unsigned TO = 15;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic        memRead;
  logic        memWrite;
  logic [15:0] aluOut;
  logic [15:0] writeData;
  logic [15:0] readData;
  logic        stall;
  logic        done;
  logic        err;

  memory_access_if mif ();

  memory_access #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .memRead   (memRead),
    .memWrite  (memWrite),
    .aluOut    (aluOut),
    .writeData (writeData),
    .mem       (mif),
    .readData  (readData),
    .stall     (stall),
    .done      (done),
    .err       (err)
  );

  int unsigned vectors;
  int unsigned miscompares;

  // reference state: sticky error and last completed load data
  logic        err_m;
  logic [15:0] rd_m;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end, required finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    valid_in        = 1'b0;
    memRead         = 1'b0;
    memWrite        = 1'b0;
    aluOut          = '0;
    writeData       = '0;
    mif.mem_stall   = 1'b0;
    mif.mem_done    = 1'b0;
    mif.mem_data_in = '0;
  endtask

  task automatic chk_quiet(input string tag);
    chk1({tag, "_stall"}, stall, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
    chk1({tag, "_rd"}, mif.mem_rd, 1'b0);
    chk1({tag, "_wr"}, mif.mem_wr, 1'b0);
    chk16({tag, "_addr"}, mif.mem_addr, 16'h0000);
    chk16({tag, "_wdata"}, mif.mem_data_out, 16'h0000);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    #1;
    chk_quiet("in_rst");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_quiet("post_rst");
    chk16("post_rst_rdata", readData, 16'h0000);
    chk1("post_rst_err", err, 1'b0);
    err_m = 1'b0;
    rd_m  = '0;
  endtask

  // One pipeline request followed by a scripted memory: s cycles of
  // mem_stall while requesting, then the response d cycles after release.
  task automatic run_txn(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [15:0] wd, input logic [15:0] rdat,
                         input int unsigned s, input int unsigned d);
    logic        acc;
    logic        bad;
    logic        to;
    int unsigned dd;
    int unsigned busy;
    int unsigned win;
    int unsigned rd_n;
    int unsigned wr_n;
    int unsigned st_n;
    int unsigned dn_n;
    int unsigned dn_k;
    acc  = !err_m && (rd ^ wr) && !a[0];
    bad  = !err_m && (rd | wr) && !acc;
    to   = acc && (d > TO);
    dd   = (d > TO) ? TO : d;
    busy = acc ? (2 + s + dd) : 0;
    win  = busy + 3;
    rd_n = 0; wr_n = 0; st_n = 0; dn_n = 0; dn_k = 0;
    for (int unsigned k = 0; k < win; k++) begin
      @(negedge clk);
      if (k == 0) begin
        valid_in  = 1'b1;
        memRead   = rd;
        memWrite  = wr;
        aluOut    = a;
        writeData = wd;
      end else if (k <= busy) begin
        valid_in  = 1'($urandom);
        memRead   = 1'($urandom);
        memWrite  = 1'($urandom);
        aluOut    = 16'($urandom);
        writeData = 16'($urandom);
      end else begin
        valid_in = 1'b0;
      end
      if (!acc || k == 0) begin
        mif.mem_stall = 1'($urandom);
        mif.mem_done  = (k == 0) ? 1'b0 : 1'($urandom);
      end else if (k <= s) begin
        mif.mem_stall = 1'b1;
        mif.mem_done  = 1'($urandom);
      end else if (k == s + 1) begin
        mif.mem_stall = 1'b0;
        mif.mem_done  = (d == 0);
      end else if (k < busy) begin
        mif.mem_stall = 1'($urandom);
        mif.mem_done  = (k - (s + 1) == d);
      end else begin
        mif.mem_stall = 1'($urandom);
        mif.mem_done  = 1'($urandom);
      end
      mif.mem_data_in = (acc && !to && k == s + 1 + d) ? rdat : 16'($urandom);
      #1;
      if (mif.mem_rd) rd_n++;
      if (mif.mem_wr) wr_n++;
      if (stall) st_n++;
      if (done) begin
        dn_n++;
        dn_k = k;
      end
      if (acc && k > 0 && k < busy) begin
        chk16("busy_addr", mif.mem_addr, a);
        chk16("busy_wdata", mif.mem_data_out, wd);
      end else begin
        chk16("idle_addr", mif.mem_addr, 16'h0000);
        chk16("idle_wdata", mif.mem_data_out, 16'h0000);
      end
      if (k == 0) begin
        chk1("accept_stall", stall, acc);
        chk1("err_before", err, err_m);
      end
      if (k == 1 && bad) chk1("bad_err", err, 1'b1);
    end
    valid_in     = 1'b0;
    mif.mem_done = 1'b0;
    chk16("rd_cycles", 16'(rd_n), (acc && rd) ? 16'(s + 1) : 16'h0000);
    chk16("wr_cycles", 16'(wr_n), (acc && wr) ? 16'(s + 1) : 16'h0000);
    chk16("stall_cycles", 16'(st_n), 16'(busy));
    chk16("done_pulses", 16'(dn_n), (acc && !to) ? 16'h0001 : 16'h0000);
    if (acc && !to) chk16("done_cycle", 16'(dn_k), 16'(busy));
    if (acc && rd && !to) rd_m = rdat;
    if (bad || to) err_m = 1'b1;
    chk16("readData", readData, rd_m);
    chk1("err_after", err, err_m);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    err_m       = 1'b0;
    rd_m        = '0;
    rst         = 1'b1;
    idle_inputs();

    do_reset();

    // load, no stall, immediate response
    run_txn(1'b1, 1'b0, 16'h0010, 16'h5555, 16'hBEEF, 0, 0);
    chk16("load_beef", readData, 16'hBEEF);

    // store held by 3 stall cycles, response 2 cycles after release
    run_txn(1'b0, 1'b1, 16'h0100, 16'h1234, 16'hDEAD, 3, 2);
    chk16("store_keeps_rdata", readData, 16'hBEEF);

    // five cycles of non-memory instructions
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge clk);
      valid_in = 1'b1;
      memRead  = 1'b0;
      memWrite = 1'b0;
      aluOut   = 16'($urandom);
      #1;
      chk_quiet("nonmem");
    end
    valid_in = 1'b0;

    // unaligned load faults, later valid load is refused
    run_txn(1'b1, 1'b0, 16'h0011, 16'h0000, 16'h1111, 0, 0);
    run_txn(1'b1, 1'b0, 16'h0020, 16'h0000, 16'h2222, 0, 0);
    chk1("err_sticky", err, 1'b1);
    chk16("refused_rdata", readData, 16'hBEEF);

    // both op flags set is a fault too
    do_reset();
    run_txn(1'b1, 1'b1, 16'h0040, 16'h0000, 16'h3333, 0, 0);

    // timeout: no response ever
    do_reset();
    run_txn(1'b1, 1'b0, 16'h0080, 16'h0000, 16'h4444, 0, 40);
    chk16("timeout_rdata", readData, 16'h0000);

    // response on the last allowed WAIT cycle still completes
    do_reset();
    run_txn(1'b1, 1'b0, 16'h00A0, 16'h0000, 16'hC0DE, 1, TO);

    // reset while waiting, then a stray late response
    do_reset();
    @(negedge clk);
    valid_in = 1'b1; memRead = 1'b1; memWrite = 1'b0; aluOut = 16'h0040;
    for (int unsigned k = 1; k <= 3; k++) begin
      @(negedge clk);
      valid_in = 1'b0; mif.mem_stall = 1'b0; mif.mem_done = 1'b0;
      #1;
      chk1("wait_stall", stall, 1'b1);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_quiet("rst_in_wait");
    for (int unsigned k = 0; k < 2; k++) begin
      @(negedge clk);
      rst = 1'b0; mif.mem_done = 1'b1; mif.mem_data_in = 16'hAAAA;
      #1;
      chk_quiet("late_done");
      chk16("late_done_rdata", readData, 16'h0000);
      chk1("late_done_err", err, 1'b0);
    end
    mif.mem_done = 1'b0;
    err_m = 1'b0;
    rd_m  = '0;

    // randomized traffic
    for (int unsigned n = 0; n < 200; n++) begin
      int unsigned c;
      int unsigned sel;
      int unsigned s;
      int unsigned d;
      logic        rd;
      logic        wr;
      logic [15:0] a;
      c   = $urandom_range(0, 9);
      s   = $urandom_range(0, 3);
      sel = $urandom_range(0, 9);
      d   = (sel == 0) ? $urandom_range(TO + 1, TO + 3)
          : (sel == 1) ? TO : $urandom_range(0, 5);
      a   = 16'($urandom);
      rd  = 1'($urandom);
      wr  = !rd;
      if (c == 0) begin
        rd = 1'b0; wr = 1'b0;
      end else if (c == 1) begin
        rd = 1'b1; wr = 1'b1; a[0] = 1'b0;
      end else if (c == 2) begin
        a[0] = 1'b1;
      end else begin
        a[0] = 1'b0;
      end
      run_txn(rd, wr, a, 16'($urandom), 16'($urandom), s, d);
      if (err_m && $urandom_range(0, 2) != 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
